// File: rtl/hazard_pkg.sv
// Shared constants, FSM state type and opcode decode helpers for the
// decode-stage hazard / NPU stall controller.
package hazard_pkg;

  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_IALU    = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;

  localparam logic [6:0] MATR_FUNCT7 = 7'b0000011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2,
    ST_DONE = 2'd3
  } npu_state_e;

  // rs1 is read by every supported opcode; anything else never hazards.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    logic used;
    case (opcode)
      OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH: used = 1'b1;
      default:                                     used = 1'b0;
    endcase
    return used;
  endfunction

  // rs2 is read only by register-register ALU ops, stores and branches.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    logic used;
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: used = 1'b1;
      default:                   used = 1'b0;
    endcase
    return used;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Signal bundle between the decode stage / NPU and the hazard stall unit.
// The master side drives instruction fields and NPU handshake inputs; the
// slave side (the stall unit) returns pipeline control.
interface hazard_stall_unit_if;

  logic [6:0] id_opcode;
  logic [6:0] id_funct7;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       npu_ready;
  logic       npu_done;

  logic       ctrl_src;
  logic       pc_write;
  logic       ifid_write;
  logic       npu_stall;
  logic       npu_start;
  logic       npu_timeout;

  modport master (
    output id_opcode, id_funct7, id_rs1, id_rs2, ex_mem_read, ex_rd,
           npu_ready, npu_done,
    input  ctrl_src, pc_write, ifid_write, npu_stall, npu_start, npu_timeout
  );

  modport slave (
    input  id_opcode, id_funct7, id_rs1, id_rs2, ex_mem_read, ex_rd,
           npu_ready, npu_done,
    output ctrl_src, pc_write, ifid_write, npu_stall, npu_start, npu_timeout
  );

endinterface

// File: rtl/hazard_stall_unit_npu_watchdog.sv
// Busy-cycle counter for the NPU job. Cleared when the job is launched,
// advanced once per busy cycle; tc_o marks the busy cycle on which the
// count reaches all-ones, i.e. the (2^TIMEOUT_W - 1)-th busy cycle.
module npu_watchdog #(
  parameter int unsigned TIMEOUT_W = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] TC_VAL  = CNT_MAX - CNT_ONE;

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  // Next count: clear has priority over increment, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count: this busy cycle brings the counter to all-ones.
  // Deliberately independent of en_i so the FSM can consume it without a
  // combinational loop through its own enable.
  always_comb begin
    tc_o = (cnt_q == TC_VAL);
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard and stall controller. Inserts a one-cycle bubble on
// load-use hazards and sequences the NPU handshake for the matr
// instruction, freezing the pipeline until the NPU finishes or the
// watchdog expires.
module hazard_stall_unit #(
  parameter int unsigned TIMEOUT_W = 10
) (
  input logic               clk,
  input logic               reset,
  hazard_stall_unit_if.slave bus
);

  import hazard_pkg::*;

  npu_state_e state_q;
  npu_state_e state_d;
  logic       timeout_q;
  logic       timeout_d;

  logic matr_id_s;
  logic rs1_hit_s;
  logic rs2_hit_s;
  logic load_use_s;
  logic wd_clr_s;
  logic wd_en_s;
  logic wd_tc_s;
  logic npu_stall_s;
  logic npu_start_s;
  logic ctrl_src_s;
  logic pc_write_s;
  logic ifid_write_s;

  // Instruction decode: matr detection and load-use hazard against ID/EX.
  always_comb begin
    matr_id_s  = (bus.id_opcode == OP_R) && (bus.id_funct7 == MATR_FUNCT7);
    rs1_hit_s  = uses_rs1(bus.id_opcode) && (bus.ex_rd == bus.id_rs1);
    rs2_hit_s  = uses_rs2(bus.id_opcode) && (bus.ex_rd == bus.id_rs2);
    load_use_s = bus.ex_mem_read && (bus.ex_rd != 5'd0) && (rs1_hit_s || rs2_hit_s);
  end

  npu_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_npu_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr_i (wd_clr_s),
    .en_i  (wd_en_s),
    .tc_o  (wd_tc_s)
  );

  // NPU sequencing FSM: next state, stall/start and watchdog control.
  // A matr that coincides with a load-use hazard waits for the bubble.
  always_comb begin
    state_d     = state_q;
    timeout_d   = timeout_q;
    wd_clr_s    = 1'b0;
    wd_en_s     = 1'b0;
    npu_stall_s = 1'b0;
    npu_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (matr_id_s && !load_use_s) begin
          npu_stall_s = 1'b1;
          state_d     = ST_REQ;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_REQ: begin
        npu_stall_s = 1'b1;
        npu_start_s = bus.npu_ready;
        if (bus.npu_ready) begin
          wd_clr_s = 1'b1;
          state_d  = ST_BUSY;
        end else begin
          state_d  = ST_REQ;
        end
      end
      ST_BUSY: begin
        npu_stall_s = 1'b1;
        wd_en_s     = 1'b1;
        if (bus.npu_done) begin
          state_d   = ST_DONE;
        end else if (wd_tc_s) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          state_d   = ST_BUSY;
        end
      end
      ST_DONE: begin
        // Stall drops so matr leaves ID; returning to IDLE unconditionally
        // keeps the same instruction from launching a second job.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pipeline control: bubble on load-use, freeze PC and IF/ID on any stall.
  always_comb begin
    ctrl_src_s = load_use_s;
    if (load_use_s || npu_stall_s) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
    end else begin
      pc_write_s   = 1'b1;
      ifid_write_s = 1'b1;
    end
  end

  // State and sticky timeout flag; reset aborts any job without notifying
  // the NPU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.ctrl_src    = ctrl_src_s;
  assign bus.pc_write    = pc_write_s;
  assign bus.ifid_write  = ifid_write_s;
  assign bus.npu_stall   = npu_stall_s;
  assign bus.npu_start   = npu_start_s;
  assign bus.npu_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit (TIMEOUT_W = 3, so the
// watchdog fires on the 7th busy cycle). Expected outputs come from a
// job-level reference model kept here.
module tb_hazard_stall_unit;

  localparam int unsigned TW       = 3;
  localparam int          WD_LIMIT = (1 << TW) - 1;

  localparam logic [6:0] T_R      = 7'b0110011;
  localparam logic [6:0] T_IALU   = 7'b0010011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_MATR7  = 7'b0000011;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_unit_if bus_if ();

  hazard_stall_unit #(.TIMEOUT_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: job-level bookkeeping.
  bit m_active;    // a matr job is in flight (accepted, not yet released)
  bit m_launched;  // the NPU has been handed the job
  bit m_release;   // this cycle is the single release cycle
  bit m_timeout;   // sticky watchdog error
  int m_busy;      // busy cycles elapsed since launch
  bit m_lu, m_matr, m_rdy, m_dn;

  // {ctrl_src, pc_write, ifid_write, npu_stall, npu_start, npu_timeout}
  logic [5:0] exp_v;
  logic [5:0] obs_v;

  task automatic model_reset();
    m_active = 0; m_launched = 0; m_release = 0; m_timeout = 0; m_busy = 0;
  endtask

  task automatic eval_model();
    bit supported, rs2_used, lu, stall, start;
    logic [6:0] op;
    op        = bus_if.id_opcode;
    supported = (op == T_R) || (op == T_IALU) || (op == T_LOAD) ||
                (op == T_STORE) || (op == T_BRANCH);
    rs2_used  = (op == T_R) || (op == T_STORE) || (op == T_BRANCH);
    lu = bus_if.ex_mem_read && (bus_if.ex_rd != 5'd0) && supported &&
         ((bus_if.ex_rd == bus_if.id_rs1) ||
          (rs2_used && (bus_if.ex_rd == bus_if.id_rs2)));
    m_matr = (op == T_R) && (bus_if.id_funct7 == T_MATR7);
    m_lu   = lu;
    m_rdy  = bus_if.npu_ready;
    m_dn   = bus_if.npu_done;
    stall = 0; start = 0;
    if (m_release) begin
      stall = 0;
    end else if (m_active && !m_launched) begin
      stall = 1; start = m_rdy;
    end else if (m_active) begin
      stall = 1;
    end else begin
      stall = m_matr && !lu;
    end
    exp_v = {lu, !(lu || stall), !(lu || stall), stall, start, m_timeout};
  endtask

  task automatic advance_model();
    if (m_release) begin
      m_release = 0; m_active = 0; m_launched = 0;
    end else if (m_active && !m_launched) begin
      if (m_rdy) begin m_launched = 1; m_busy = 0; end
    end else if (m_active) begin
      m_busy++;
      if (m_dn) m_release = 1;
      else if (m_busy == WD_LIMIT) begin m_timeout = 1; m_release = 1; end
    end else if (m_matr && !m_lu) begin
      m_active = 1; m_launched = 0;
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [6:0] f7,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic mr, input logic [4:0] rd,
                       input logic rdy, input logic dn);
    bus_if.id_opcode   = op;
    bus_if.id_funct7   = f7;
    bus_if.id_rs1      = rs1;
    bus_if.id_rs2      = rs2;
    bus_if.ex_mem_read = mr;
    bus_if.ex_rd       = rd;
    bus_if.npu_ready   = rdy;
    bus_if.npu_done    = dn;
    #1;
    eval_model();
    obs_v = {bus_if.ctrl_src, bus_if.pc_write, bus_if.ifid_write,
             bus_if.npu_stall, bus_if.npu_start, bus_if.npu_timeout};
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset(); else advance_model();
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(T_IALU, 7'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    total++;
    if (obs_v !== exp_v) begin bad++; $display("FAIL reset_idle got=%b want=%b", obs_v, exp_v); end
    total++;
    if (obs_v !== 6'b011000) begin bad++; $display("FAIL reset_defaults got=%b want=%b", obs_v, 6'b011000); end
    tick();
    drive(T_R, T_MATR7, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    total++;
    if (obs_v !== exp_v) begin bad++; $display("FAIL reset_matr_decode got=%b want=%b", obs_v, exp_v); end
    tick();
    reset = 1'b0;
    drive(T_IALU, 7'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    total++;
    if (obs_v !== exp_v) begin bad++; $display("FAIL reset_release got=%b want=%b", obs_v, exp_v); end
    tick();
  endtask

  task automatic test_load_use();
    drive(T_R, 7'd0, 5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0);
    total++;
    if (obs_v !== exp_v) begin bad++; $display("FAIL load_use got=%b want=%b", obs_v, exp_v); end
    total++;
    if (obs_v[5:3] !== 3'b100) begin bad++; $display("FAIL load_use_bubble got=%b want=%b", obs_v[5:3], 3'b100); end
    tick();
    drive(T_R, 7'd0, 5'd5, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);
    total++;
    if (obs_v !== exp_v) begin bad++; $display("FAIL load_use_release got=%b want=%b", obs_v, exp_v); end
    tick();
  endtask

  task automatic test_zero_and_filters();
    logic [6:0] ops [5];
    logic [4:0] r2  [5];
    ops[0] = T_R;     r2[0] = 5'd9;   // ex_rd == 0 via rs1 == 0
    ops[1] = T_IALU;  r2[1] = 5'd7;   // rs2 unused by I-type
    ops[2] = T_STORE; r2[2] = 5'd7;   // rs2 used by store
    ops[3] = T_LOAD;  r2[3] = 5'd7;   // rs2 unused by load
    ops[4] = T_JAL;   r2[4] = 5'd7;   // unsupported opcode
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(ops[i], 7'd0, 5'd0, r2[i], 1'b1, 5'd0, 1'b0, 1'b0);
      else        drive(ops[i], 7'd0, 5'd3, r2[i], 1'b1, 5'd7, 1'b0, 1'b0);
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL filter case=%0d got=%b want=%b", i, obs_v, exp_v); end
      total++;
      if (obs_v[5] !== ((i == 2) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL filter_bubble case=%0d got=%b want=%b", i, obs_v[5], (i == 2));
      end
      tick();
    end
  endtask

  task automatic test_npu_normal();
    int n_start = 0, n_stall = 0;
    for (int i = 0; i < 9; i++) begin
      drive((i <= 6) ? T_R : T_IALU, (i <= 6) ? T_MATR7 : 7'd0, 5'd1, 5'd2,
            1'b0, 5'd0, 1'b1, (i == 5));
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL npu_normal cyc=%0d got=%b want=%b", i, obs_v, exp_v); end
      n_start += int'(bus_if.npu_start);
      n_stall += int'(bus_if.npu_stall);
      tick();
    end
    total++;
    if (n_start !== 1) begin bad++; $display("FAIL npu_normal_starts got=%0d want=1", n_start); end
    total++;
    if (n_stall !== 6) begin bad++; $display("FAIL npu_normal_stall_cycles got=%0d want=6", n_stall); end
  endtask

  task automatic test_req_wait();
    int n_start = 0, start_at = -1;
    for (int i = 0; i < 17; i++) begin
      drive((i <= 14) ? T_R : T_IALU, (i <= 14) ? T_MATR7 : 7'd0, 5'd1, 5'd2,
            1'b0, 5'd0, (i >= 11), (i == 13));
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL req_wait cyc=%0d got=%b want=%b", i, obs_v, exp_v); end
      if (bus_if.npu_start === 1'b1) begin n_start++; start_at = i; end
      tick();
    end
    total++;
    if (n_start !== 1 || start_at !== 11) begin
      bad++; $display("FAIL req_wait_start got=%0d@%0d want=1@11", n_start, start_at);
    end
    total++;
    if (bus_if.npu_timeout !== 1'b0) begin bad++; $display("FAIL req_wait_timeout got=%b want=0", bus_if.npu_timeout); end
  endtask

  task automatic test_watchdog(input bit done_on_tc);
    for (int i = 0; i < 15; i++) begin
      drive((i <= 9) ? T_R : T_IALU, (i <= 9) ? T_MATR7 : 7'd0, 5'd1, 5'd2,
            1'b0, 5'd0, 1'b1, done_on_tc && (i == 8));
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL watchdog tc_done=%0d cyc=%0d got=%b want=%b", done_on_tc, i, obs_v, exp_v); end
      if (i == 9) begin
        total++;
        if ({bus_if.npu_stall, bus_if.npu_timeout} !== {1'b0, !done_on_tc}) begin
          bad++; $display("FAIL watchdog_done tc_done=%0d got=%b%b want=0%b", done_on_tc,
                          bus_if.npu_stall, bus_if.npu_timeout, !done_on_tc);
        end
      end
      tick();
    end
    total++;
    if (bus_if.npu_timeout !== !done_on_tc) begin
      bad++; $display("FAIL watchdog_sticky tc_done=%0d got=%b want=%b", done_on_tc, bus_if.npu_timeout, !done_on_tc);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      drive(T_R, T_MATR7, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL areset_pre cyc=%0d got=%b want=%b", i, obs_v, exp_v); end
      if (i < 4) tick();
    end
    #1;
    reset = 1'b1;
    model_reset();
    drive(T_IALU, 7'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    total++;
    if (obs_v !== exp_v) begin bad++; $display("FAIL areset_now got=%b want=%b", obs_v, exp_v); end
    total++;
    if ({bus_if.npu_stall, bus_if.npu_timeout} !== 2'b00) begin
      bad++; $display("FAIL areset_clear got=%b%b want=00", bus_if.npu_stall, bus_if.npu_timeout);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(T_IALU, 7'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1);
      total++;
      if (obs_v !== exp_v || obs_v !== 6'b011000) begin
        bad++; $display("FAIL areset_late_done cyc=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    ops[0] = T_R; ops[1] = T_IALU; ops[2] = T_LOAD;
    ops[3] = T_STORE; ops[4] = T_BRANCH; ops[5] = T_JAL;
    for (int i = 0; i < 400; i++) begin
      drive(ops[$urandom_range(0, 5)],
            ($urandom_range(0, 2) == 0) ? T_MATR7 : 7'd0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
      total++;
      if (obs_v !== exp_v) begin bad++; $display("FAIL random cyc=%0d got=%b want=%b", i, obs_v, exp_v); end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL tb_time_limit total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    model_reset();
    bus_if.id_opcode = T_IALU; bus_if.id_funct7 = 7'd0;
    bus_if.id_rs1 = 5'd0; bus_if.id_rs2 = 5'd0;
    bus_if.ex_mem_read = 1'b0; bus_if.ex_rd = 5'd0;
    bus_if.npu_ready = 1'b0; bus_if.npu_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_zero_and_filters();
    test_npu_normal();
    test_req_wait();
    test_watchdog(1'b1);
    test_watchdog(1'b0);
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Decode-stage hazard and stall controller; sits directly upstream of the pipeline control decoder and produces its `CtrlSrc` and `npu_stall` inputs. It detects load-use hazards and inserts a one-cycle bubble. It also sequences the NPU handshake for the `matr` instruction, freezing the pipeline until the NPU finishes or a watchdog expires.

## Interface
Parameters:
- `TIMEOUT_W`, 10, width of the NPU watchdog counter; timeout fires after 2^TIMEOUT_W−1 busy cycles.

Ports:
- `clk`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-high reset.
- `id_opcode`  in  7  opcode of the instruction in IF/ID.
- `id_funct7`  in  7  funct7 of the instruction in IF/ID.
- `id_rs1`, `id_rs2`  in  5  source registers of the instruction in IF/ID.
- `ex_mem_read`  in  1  MEMRead bit of the instruction in ID/EX.
- `ex_rd`  in  5  destination register of the instruction in ID/EX.
- `npu_ready`  in  1  NPU can accept a job.
- `npu_done`  in  1  single-cycle NPU completion pulse.
- `ctrl_src`  out  1  bubble request to the control decoder.
- `pc_write`  out  1  PC update enable.
- `ifid_write`  out  1  IF/ID register write enable.
- `npu_stall`  out  1  freezes all pipeline registers.
- `npu_start`  out  1  single-cycle job launch to the NPU.
- `npu_timeout`  out  1  sticky watchdog error flag.

## Operation
- `matr_id` = (`id_opcode`==7'b0110011) && (`id_funct7`==MATR_FUNCT7).
- `uses_rs2` is true for opcodes 0110011, 0100011 and 1100011. `rs1` is used by all five supported opcodes. Unsupported opcodes never hazard.
- `load_use` = `ex_mem_read` && `ex_rd`≠0 && (`ex_rd`==`id_rs1` || (`uses_rs2` && `ex_rd`==`id_rs2`)).
- When `load_use` is true:
  - `ctrl_src`=1, `pc_write`=0, `ifid_write`=0.
  - Load-use has priority over NPU detection in the same cycle.
- FSM states are IDLE, REQ, BUSY and DONE.
  - IDLE: if `matr_id` && !`load_use`, assert `npu_stall` combinationally and go to REQ.
  - REQ: `npu_stall`=1. `npu_start` = `npu_ready`. If `npu_ready`, clear the counter and go to BUSY. Otherwise stay in REQ; REQ has no timeout.
  - BUSY: `npu_stall`=1 and the counter increments.
    - If `npu_done`, go to DONE.
    - Else if the counter equals all-ones, set `npu_timeout` and go to DONE.
    - If `npu_done` and the terminal count coincide, done wins and the flag is not set.
  - DONE: `npu_stall`=0, so `matr` advances out of ID this cycle. Go to IDLE unconditionally; this prevents re-triggering on the same instruction.
- While `npu_stall`=1:
  - `pc_write`=0 and `ifid_write`=0.
  - `ctrl_src` may be 1, but the decoder ignores it.
- `npu_done` is ignored in IDLE, REQ and DONE.
- `npu_timeout` is cleared only by `reset`.
- Default outputs: `ctrl_src`=0, `pc_write`=1, `ifid_write`=1, `npu_stall`=0, `npu_start`=0.

## Timing
- Reset values (asynchronous): state=IDLE, counter=0, `npu_timeout`=0. All other outputs take their defaults, decoded from IDLE with current inputs.
- Load-use hazard: exactly one bubble cycle. The cycle after, `ex_mem_read` belongs to the bubble and the stall releases.
- NPU sequence, with `matr` detected in cycle T:
  - T: IDLE, stall asserted.
  - T+1: REQ; `npu_start` here if `npu_ready`.
  - T+2: BUSY.
  - `npu_done` in cycle D gives DONE at D+1, with stall low.
  - D+2: IDLE.
  - Minimum stall is 3 cycles (T through T+2, with done at T+2).
- Watchdog: BUSY lasts at most 2^TIMEOUT_W−1 cycles.
- `npu_start` is never asserted in two consecutive cycles.
- Reset mid-sequence aborts to IDLE. The NPU is not notified.

## Structure
- Shared package `hazard_pkg` holds:
  - Opcode constants: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - MATR_FUNCT7 = 7'b0000011.
  - The FSM state enum.
- One sub-module is natural: `npu_watchdog`, a TIMEOUT_W-bit counter with clear, enable and terminal-count output. Everything else stays flat.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, R-type → one cycle of `ctrl_src`=1, `pc_write`=0, `ifid_write`=0; defaults the next cycle.
- Zero-register filter: same as above with `ex_rd`=0 → no bubble. Also an I-type with `id_rs2`==`ex_rd`=7 → no bubble.
- NPU normal path: `matr` in ID, `npu_ready`=1, `npu_done` 4 cycles after start → `npu_start` pulses once, `npu_stall` high continuously until DONE, then low for 1 cycle, then IDLE.
- REQ wait: `npu_ready`=0 for 10 cycles then 1 → stall is held throughout, `npu_start` fires on the first ready cycle, and no timeout occurs.
- Watchdog: TIMEOUT_W=3, no `npu_done` → DONE after 7 BUSY cycles, `npu_timeout`=1 and sticky until reset. Repeat with done on the terminal cycle → flag stays 0.
- Async reset asserted in BUSY → immediately state=IDLE, `npu_stall`=0, `npu_timeout`=0, and a later `npu_done` has no effect.
